// File: rtl/lstm_pkg.sv
// Shared LSTM accelerator constants and the memory loader state encoding.
package lstm_pkg;

   localparam int LSTM_DWIDTH  = 16;
   localparam int LSTM_MEMSIZE = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } loader_state_t;

endpackage

// File: rtl/mem_loader_out_fifo2.sv
// Two-entry FIFO used as the skid buffer between the memory read port and the output stream.
module out_fifo2 #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [1:0]       o_count,
   output logic [WIDTH-1:0] o_head
);

   logic [WIDTH-1:0] r_slot [2];
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPop  = i_pop && (r_count != 2'd0);
   assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);
   assign o_count  = r_count;
   assign o_head   = r_slot[r_rdPtr];

   // Simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int i = 0; i < 2; i++) r_slot[i] <= '0;
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_slot[r_wrPtr] <= i_data;
            r_wrPtr         <= ~r_wrPtr;
         end
         if (w_doPop) r_rdPtr <= ~r_rdPtr;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Loads an input word stream into an attached single-port memory and streams
// memory regions back out through a 2-entry skid buffer.
module mem_loader
   import lstm_pkg::*;
#(
   parameter int DWIDTH  = LSTM_DWIDTH,
   parameter int MEMSIZE = LSTM_MEMSIZE,
   parameter int AWIDTH  = $clog2(MEMSIZE)
) (
   input  logic              clk,
   input  logic              xrst,
   input  logic              load_start,
   input  logic [AWIDTH-1:0] load_base,
   input  logic [AWIDTH:0]   load_len,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   input  logic              read_start,
   input  logic [AWIDTH-1:0] read_base,
   input  logic [AWIDTH:0]   read_len,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEMSIZE - 1);
   localparam logic [AWIDTH:0]   LEN_ONE   = (AWIDTH + 1)'(1);

   loader_state_t     r_state;
   logic [AWIDTH-1:0] r_wrAddr;
   logic [AWIDTH-1:0] r_rdAddr;
   logic [AWIDTH:0]   r_wrRemain;
   logic [AWIDTH:0]   r_rdRemain;
   logic [AWIDTH-1:0] r_addrHold;
   logic [DWIDTH-1:0] r_wdataHold;
   logic              r_inFlight;
   logic              r_inFlightLast;

   logic              w_write;
   logic              w_issue;
   logic              w_pop;
   logic [1:0]        w_count;
   logic [1:0]        w_occAfterPop;
   logic [DWIDTH:0]   w_head;

   function automatic logic [AWIDTH-1:0] nextAddr(input logic [AWIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   assign busy      = (r_state != ST_IDLE);
   assign in_ready  = (r_state == ST_LOAD);
   assign w_write   = in_ready && in_valid;
   assign out_valid = (w_count != 2'd0);
   assign w_pop     = out_valid && out_ready;

   // Counting the word leaving this cycle as already gone keeps the stream bubble-free
   // while occupancy plus in-flight reads never exceeds the two FIFO slots.
   assign w_occAfterPop = w_count - {1'b0, w_pop};
   assign w_issue       = (r_state == ST_READ) && ((w_occAfterPop + {1'b0, r_inFlight}) < 2'd2);

   assign mem_we    = w_write;
   assign mem_addr  = w_write ? r_wrAddr : (w_issue ? r_rdAddr : r_addrHold);
   assign mem_wdata = w_write ? in_data : r_wdataHold;
   assign out_data  = w_head[DWIDTH-1:0];
   assign out_last  = out_valid && w_head[DWIDTH];

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_state    <= ST_IDLE;
         r_wrAddr   <= '0;
         r_rdAddr   <= '0;
         r_wrRemain <= '0;
         r_rdRemain <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A load command masks a same-cycle read, even when the load is zero-length.
               if (load_start) begin
                  if (load_len != '0) begin
                     r_state    <= ST_LOAD;
                     r_wrAddr   <= load_base;
                     r_wrRemain <= load_len;
                  end
               end else if (read_start && (read_len != '0)) begin
                  r_state    <= ST_READ;
                  r_rdAddr   <= read_base;
                  r_rdRemain <= read_len;
               end
            end
            ST_LOAD: begin
               if (w_write) begin
                  r_wrAddr   <= nextAddr(r_wrAddr);
                  r_wrRemain <= r_wrRemain - 1'b1;
                  if (r_wrRemain == LEN_ONE) r_state <= ST_IDLE;
               end
            end
            ST_READ: begin
               if (w_issue) begin
                  r_rdAddr   <= nextAddr(r_rdAddr);
                  r_rdRemain <= r_rdRemain - 1'b1;
                  if (r_rdRemain == LEN_ONE) r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if ((w_count == 2'd0) && !r_inFlight) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_inFlight     <= 1'b0;
         r_inFlightLast <= 1'b0;
         r_addrHold     <= '0;
         r_wdataHold    <= '0;
      end else begin
         r_inFlight     <= w_issue;
         r_inFlightLast <= w_issue && (r_rdRemain == LEN_ONE);
         r_addrHold     <= mem_addr;
         r_wdataHold    <= mem_wdata;
      end
   end

   out_fifo2 #(
      .WIDTH(DWIDTH + 1)
   ) u_outFifo (
      .clk    (clk),
      .xrst   (xrst),
      .i_push (r_inFlight),
      .i_data ({r_inFlightLast, mem_rdata}),
      .i_pop  (w_pop),
      .o_count(w_count),
      .o_head (w_head)
   );

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 1-cycle-latency memory beside it.
module tb_mem_loader;

   localparam int DW = 16;
   localparam int MS = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          xrst;
   logic          load_start;
   logic [AW-1:0] load_base;
   logic [AW:0]   load_len;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          read_start;
   logic [AW-1:0] read_base;
   logic [AW:0]   read_len;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   logic [DW-1:0] mem    [MS];
   logic [DW-1:0] shadow [MS];
   logic [DW-1:0] loadData [$];
   int errors = 0;
   int checks = 0;

   mem_loader #(.DWIDTH(DW), .MEMSIZE(MS), .AWIDTH(AW)) dut (
      .clk       (clk),
      .xrst      (xrst),
      .load_start(load_start),
      .load_base (load_base),
      .load_len  (load_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .read_start(read_start),
      .read_base (read_base),
      .read_len  (read_len),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Single-port memory with registered read data.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready, out_valid, out_last, busy, mem_we} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: in_ready,out_valid,out_last,busy,mem_we=%b expected 00000",
                  {in_ready, out_valid, out_last, busy, mem_we});
      end
      checks++;
      if (out_data !== 16'h0) begin
         errors++; $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data);
      end
      checks++;
      if (mem_addr !== 10'd0) begin
         errors++; $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_addr);
      end
      checks++;
      if (mem_wdata !== 16'h0) begin
         errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0000", mem_wdata);
      end
   endtask

   task automatic test_load(input logic [AW-1:0] base, input int len, input bit withRead, input string tag);
      logic [AW-1:0] expAddr;
      logic [AW-1:0] lastAddr;
      load_start = 1'b1;
      load_base  = base;
      load_len   = (AW + 1)'(len);
      read_start = withRead;
      read_base  = '0;
      read_len   = 11'd4;
      nextCycle();
      load_start = 1'b0;
      read_start = 1'b0;
      for (int i = 0; i < len; i++) begin
         expAddr  = AW'((int'(base) + i) % MS);
         in_valid = 1'b1;
         in_data  = loadData[i];
         #1;
         checks++;
         if (mem_we !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_we[%0d]: mem_we=%0b in_ready=%0b busy=%0b expected 1,1,1",
                     tag, i, mem_we, in_ready, busy);
         end
         checks++;
         if (mem_addr !== expAddr) begin
            errors++; $display("[TB] FAIL %s_addr[%0d]: got %0d expected %0d", tag, i, mem_addr, expAddr);
         end
         checks++;
         if (mem_wdata !== loadData[i]) begin
            errors++; $display("[TB] FAIL %s_wdata[%0d]: got %h expected %h", tag, i, mem_wdata, loadData[i]);
         end
         shadow[expAddr] = loadData[i];
         nextCycle();
      end
      lastAddr = AW'((int'(base) + len - 1) % MS);
      in_data  = 16'hDEAD;
      #1;
      checks++;
      if (mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_done: mem_we=%0b in_ready=%0b busy=%0b expected 0,0,0",
                  tag, mem_we, in_ready, busy);
      end
      checks++;
      if (mem_addr !== lastAddr) begin
         errors++; $display("[TB] FAIL %s_addr_hold: got %0d expected %0d", tag, mem_addr, lastAddr);
      end
      in_valid = 1'b0;
      nextCycle();
   endtask

   task automatic test_read(input logic [AW-1:0] base, input int len, input int stallAt,
                            input int stallLen, input string tag);
      int idx;
      int cyc;
      int firstCyc;
      int lastCyc;
      bit weSeen;
      bit stalledPrev;
      logic [DW-1:0] held;
      logic [DW-1:0] expData;
      read_start = 1'b1;
      read_base  = base;
      read_len   = (AW + 1)'(len);
      out_ready  = 1'b1;
      nextCycle();
      read_start  = 1'b0;
      idx         = 0;
      cyc         = 0;
      firstCyc    = -1;
      lastCyc     = -1;
      weSeen      = 1'b0;
      stalledPrev = 1'b0;
      held        = '0;
      while (idx < len && cyc < 60) begin
         out_ready = (stallLen == 0) || (cyc < stallAt) || (cyc >= stallAt + stallLen);
         #1;
         if (mem_we) weSeen = 1'b1;
         if (out_valid) begin
            if (firstCyc < 0) firstCyc = cyc;
            if (!out_ready) begin
               if (stalledPrev) begin
                  checks++;
                  if (out_data !== held) begin
                     errors++; $display("[TB] FAIL %s_stable@%0d: got %h expected %h", tag, cyc, out_data, held);
                  end
               end
               held        = out_data;
               stalledPrev = 1'b1;
            end else begin
               expData = shadow[(int'(base) + idx) % MS];
               checks++;
               if (out_data !== expData) begin
                  errors++; $display("[TB] FAIL %s_data[%0d]: got %h expected %h", tag, idx, out_data, expData);
               end
               checks++;
               if (out_last !== (idx == len - 1)) begin
                  errors++;
                  $display("[TB] FAIL %s_last[%0d]: got %0b expected %0b", tag, idx, out_last, (idx == len - 1));
               end
               idx++;
               if (idx == len) lastCyc = cyc;
               stalledPrev = 1'b0;
            end
         end else begin
            stalledPrev = 1'b0;
         end
         nextCycle();
         cyc++;
      end
      checks++;
      if (idx != len) begin
         errors++; $display("[TB] FAIL %s_count: got %0d words expected %0d", tag, idx, len);
      end
      checks++;
      if (firstCyc != 2) begin
         errors++; $display("[TB] FAIL %s_latency: first valid at cycle %0d expected 2", tag, firstCyc);
      end
      checks++;
      if (lastCyc != 1 + len + stallLen) begin
         errors++; $display("[TB] FAIL %s_bubbles: last word at cycle %0d expected %0d", tag, lastCyc, 1 + len + stallLen);
      end
      checks++;
      if (weSeen) begin
         errors++; $display("[TB] FAIL %s_no_write: mem_we seen 1 expected 0", tag);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10 && busy; k++) nextCycle();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL %s_idle: busy=%0b out_valid=%0b expected 0,0", tag, busy, out_valid);
      end
   endtask

   task automatic test_reset_mid_read();
      read_start = 1'b1;
      read_base  = '0;
      read_len   = 11'd8;
      out_ready  = 1'b1;
      nextCycle();
      read_start = 1'b0;
      nextCycle();
      nextCycle();
      nextCycle();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== shadow[1]) begin
         errors++;
         $display("[TB] FAIL rst_second_word: valid=%0b data=%h expected 1,%h", out_valid, out_data, shadow[1]);
      end
      nextCycle();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("[TB] FAIL rst_busy_before: got %0b expected 1", busy);
      end
      xrst = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, busy, mem_we} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL rst_flags: in_ready,out_valid,out_last,busy,mem_we=%b expected 00000",
                  {in_ready, out_valid, out_last, busy, mem_we});
      end
      checks++;
      if (out_data !== 16'h0 || mem_addr !== 10'd0 || mem_wdata !== 16'h0) begin
         errors++;
         $display("[TB] FAIL rst_values: out_data=%h mem_addr=%0d mem_wdata=%h expected 0,0,0",
                  out_data, mem_addr, mem_wdata);
      end
      nextCycle();
      nextCycle();
      xrst = 1'b1;
      nextCycle();
      test_read(10'd0, 4, 0, 0, "after_rst");
   endtask

   task automatic test_simultaneous();
      bit activity;
      load_start = 1'b1;
      load_base  = 10'd5;
      load_len   = 11'd0;
      read_start = 1'b1;
      read_base  = 10'd0;
      read_len   = 11'd4;
      nextCycle();
      load_start = 1'b0;
      read_start = 1'b0;
      activity   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (busy || out_valid || in_ready || mem_we) activity = 1'b1;
         nextCycle();
      end
      checks++;
      if (activity) begin
         errors++; $display("[TB] FAIL simul_zero_len: activity seen 1 expected 0");
      end
      loadData.delete();
      loadData.push_back(16'hA1A1);
      loadData.push_back(16'hB2B2);
      test_load(10'd10, 2, 1'b1, "simul_load");
      activity = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (busy || out_valid) activity = 1'b1;
         nextCycle();
      end
      checks++;
      if (activity) begin
         errors++; $display("[TB] FAIL simul_read_dropped: activity seen 1 expected 0");
      end
   endtask

   initial begin
      xrst       = 1'b0;
      load_start = 1'b0;
      load_base  = '0;
      load_len   = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      read_start = 1'b0;
      read_base  = '0;
      read_len   = '0;
      out_ready  = 1'b0;
      #12;
      test_reset();
      xrst = 1'b1;
      nextCycle();

      loadData.delete();
      loadData.push_back(16'h0011);
      loadData.push_back(16'h0022);
      loadData.push_back(16'h0033);
      loadData.push_back(16'h0044);
      test_load(10'd0, 4, 1'b0, "load");
      test_read(10'd0, 4, 0, 0, "read");
      test_read(10'd0, 4, 3, 5, "stall");
      test_reset_mid_read();

      loadData.delete();
      loadData.push_back(16'h5A01);
      loadData.push_back(16'h5A02);
      loadData.push_back(16'h5A03);
      loadData.push_back(16'h5A04);
      test_load(10'd1022, 4, 1'b0, "wrap");
      test_read(10'd1022, 4, 0, 0, "wrap_rd");

      test_simultaneous();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter MEMSIZE, default 1024: depth of the attached mem_sp, in words.
REQ-003 SHALL have parameter AWIDTH, default $clog2(MEMSIZE): address and length width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port xrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports load_start (in, 1), load_base (in, AWIDTH) and load_len (in, AWIDTH+1): command to write load_len words starting at load_base.
REQ-007 SHALL have ports in_valid (in, 1), in_data (in, DWIDTH) and in_ready (out, 1): input word stream.
REQ-008 SHALL have ports read_start (in, 1), read_base (in, AWIDTH) and read_len (in, AWIDTH+1): command to stream read_len words out, starting at read_base.
REQ-009 SHALL have ports out_valid (out, 1), out_data (out, DWIDTH), out_last (out, 1) and out_ready (in, 1): output stream to the LSTM datapath.
REQ-010 SHALL have ports mem_we (out, 1), mem_addr (out, AWIDTH), mem_wdata (out, DWIDTH) and mem_rdata (in, DWIDTH): port to mem_sp, which has a 1-cycle read latency.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, READ and DRAIN.
REQ-013 IDLE: load_start with load_len>0 -> LOAD; otherwise read_start with read_len>0 -> READ; load_start wins when both are asserted in the same cycle.
REQ-014 SHALL register base and length on the accepting edge; a command with length 0 is a no-op and the FSM stays in IDLE.
REQ-015 SHALL ignore load_start and read_start whenever the FSM is outside IDLE.
REQ-016 LOAD: in_ready=1; on each in_valid&&in_ready cycle, drive mem_we=1, mem_addr=current write address, mem_wdata=in_data in that same cycle (combinational path).
REQ-017 SHALL return LOAD -> IDLE after the load_len-th accepted word; in_ready=0 in every state except LOAD.
REQ-018 SHALL increment addresses modulo MEMSIZE, so MEMSIZE-1 wraps to 0.
REQ-019 READ: issue a read (mem_we=0, mem_addr=read address) only when occupancy plus reads in flight is less than 2.
REQ-020 SHALL use a 2-entry output FIFO as the skid buffer; each read's mem_rdata is captured into it one cycle after issue.
REQ-021 READ -> DRAIN once read_len reads have been issued; DRAIN -> IDLE once the FIFO is empty and no read is in flight.
REQ-022 out_valid SHALL equal "FIFO not empty"; out_data is the FIFO head; a word pops on out_valid&&out_ready.
REQ-023 out_last SHALL be 1 exactly with the final word of a read command.
REQ-024 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-026 With out_ready held at 1, the first out_valid SHALL come 2 cycles after the read_start edge, followed by one word per cycle with no bubbles.
REQ-027 mem_addr SHALL hold its last value when unused, and mem_we SHALL be 0 whenever no write is performed.

Reset
REQ-028 While xrst=0, SHALL force state=IDLE, FIFO empty, in-flight count=0 and all address/length registers=0.
REQ-029 Reset output values SHALL be: in_ready=0, out_valid=0, out_last=0, out_data=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-030 Reset asserted mid-LOAD or mid-READ SHALL abort the command immediately, lose FIFO contents, and produce no further mem_we pulses.

Structure
REQ-031 SHALL take the FSM state enum and the default DWIDTH/MEMSIZE constants from the shared package lstm_pkg.
REQ-032 SHALL instantiate exactly one sub-module, out_fifo2: a 2-entry FIFO with push, pop, count and head outputs.
REQ-033 SHALL NOT instantiate mem_sp itself; the bench connects mem_sp next to it.

Verification
REQ-034 Load: load_base=0, load_len=4, data 0x11,0x22,0x33,0x44 with in_valid held at 1 -> mem_we high for 4 cycles at addresses 0..3, then busy=0.
REQ-035 Read: read_base=0, read_len=4, out_ready=1 -> out_data 0x11..0x44 on 4 consecutive cycles, starting 2 cycles after read_start; out_last only with 0x44.
REQ-036 Backpressure: out_ready=0 for 5 cycles mid-stream -> no word lost or duplicated; at most 2 reads outstanding; out_data held stable while stalled.
REQ-037 Wrap: load_base=MEMSIZE-2, load_len=4 -> writes go to addresses 1022, 1023, 0, 1; reading them back returns the same order.
REQ-038 Simultaneous load_start and read_start with load_len=0 -> no-op, stays IDLE; with load_len=2 -> LOAD is taken and the read is dropped.
REQ-039 xrst pulsed low during READ after 2 words -> all outputs take reset values, and a following read_start behaves as in REQ-035.
